// File: rtl/instr_pkg.sv
// Shared MIPS encoding constants, command kinds and loader FSM states.
// Imported by the encoder, the loader interface users and the loader itself.
package instr_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_JRSAL = 6'b010001;
  localparam logic [5:0] OP_BALN  = 6'b011001;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [3:0] {
    KindAdd   = 4'd0,
    KindSub   = 4'd1,
    KindAnd   = 4'd2,
    KindOr    = 4'd3,
    KindSlt   = 4'd4,
    KindLw    = 4'd5,
    KindSw    = 4'd6,
    KindBeq   = 4'd7,
    KindOri   = 4'd8,
    KindJrsal = 4'd9,
    KindBaln  = 4'd10,
    KindNop   = 4'd11
  } cmd_kind_e;

  typedef enum logic {
    StIdle  = 1'b0,
    StWrite = 1'b1
  } loader_state_e;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Command intake and imem write port of the instruction loader.
// master = host/sequencer side, slave = loader side.
interface instr_encoder_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_kind;
  logic [4:0]        cmd_rs;
  logic [4:0]        cmd_rt;
  logic [4:0]        cmd_rd;
  logic [15:0]       cmd_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ack;

  modport master (
    output cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_imm, imem_ack,
    input  cmd_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_imm, imem_ack,
    output cmd_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encode.sv
// Combinational encoder: compact command fields to a 32-bit MIPS word.
// legal is low for kinds 12-15; word is then zero and must not be written.
module instr_encode
  import instr_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    unique case (kind)
      KindAdd:   word = enc_r(rs, rt, rd, FUNCT_ADD);
      KindSub:   word = enc_r(rs, rt, rd, FUNCT_SUB);
      KindAnd:   word = enc_r(rs, rt, rd, FUNCT_AND);
      KindOr:    word = enc_r(rs, rt, rd, FUNCT_OR);
      KindSlt:   word = enc_r(rs, rt, rd, FUNCT_SLT);
      KindLw:    word = enc_i(OP_LW, rs, rt, imm);
      KindSw:    word = enc_i(OP_SW, rs, rt, imm);
      KindBeq:   word = enc_i(OP_BEQ, rs, rt, imm);
      KindOri:   word = enc_i(OP_ORI, rs, rt, imm);
      KindJrsal: word = enc_i(OP_JRSAL, rs, rt, imm);
      KindBaln:  word = enc_i(OP_BALN, rs, rt, imm);
      KindNop:   word = '0;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts encoded commands and writes them to sequential imem words,
// tracking the byte address, the word count, a full flag and a sticky error.
module instr_encoder_loader
  import instr_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  instr_encoder_loader_if.slave        bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         err
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              err_q, err_d;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              ready;

  instr_encode u_encode (
    .kind  (bus.cmd_kind),
    .rs    (bus.cmd_rs),
    .rt    (bus.cmd_rt),
    .rd    (bus.cmd_rd),
    .imm   (bus.cmd_imm),
    .word  (enc_word),
    .legal (enc_legal)
  );

  assign full           = (count_q == CntW'(DEPTH));
  assign count          = count_q;
  assign err            = err_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cmd_ready  = ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    count_d     = count_q;
    err_d       = err_q;
    ready       = 1'b0;
    bus.imem_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        // start wins over a same-cycle command, so the command is not accepted
        ready = !full && !start && !reset;
        if (start) begin
          addr_d  = ADDR_W'(BASE_ADDR);
          count_d = '0;
          err_d   = 1'b0;
        end else if (bus.cmd_valid && ready) begin
          if (enc_legal) begin
            wdata_d = enc_word;
            state_d = StWrite;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWrite: begin
        bus.imem_we = 1'b1;
        if (bus.imem_ack) begin
          state_d = StIdle;
          addr_d  = addr_q + ADDR_W'(4);
          count_d = count_q + CntW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= ADDR_W'(BASE_ADDR);
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed scenarios plus a
// randomized fill checked against a table-driven encoding and address model.
module tb_instr_encoder_loader;
  import instr_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned BASE   = 32'h40;
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] count;
  logic          full;
  logic          err;

  instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder_loader #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus),
    .count (count),
    .full  (full),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int m_count;
  bit m_err;

  // Reference encoding straight from the opcode/funct tables.
  function automatic void ref_encode(input int k, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [15:0] imm,
                                     output logic [31:0] w, output bit legal);
    logic [5:0] functs [0:4];
    logic [5:0] ops    [0:5];
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    ops    = '{6'h23, 6'h2B, 6'h04, 6'h0D, 6'h11, 6'h19};
    legal  = (k < 12);
    if (k <= 4)       w = {6'd0, rs, rt, rd, 5'd0, functs[k]};
    else if (k <= 10) w = {ops[k-5], rs, rt, imm};
    else              w = 32'h0;
  endfunction

  function automatic logic [ADDR_W-1:0] ref_addr();
    return ADDR_W'(BASE + 4 * m_count);
  endfunction

  // One command: offer, accept, then ack after ack_after WRITE cycles.
  task automatic issue(input string tag, input int k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input int ack_after,
                       input bit start_in_write);
    logic [31:0]       exp_w;
    bit                legal;
    logic [ADDR_W-1:0] exp_a;
    ref_encode(k, rs, rt, rd, imm, exp_w, legal);
    exp_a = ref_addr();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_kind  = 4'(k);
    bus.cmd_rs    = rs;
    bus.cmd_rt    = rt;
    bus.cmd_rd    = rd;
    bus.cmd_imm   = imm;
    @(negedge clk);
    n_run++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_idle: got %b want 1", tag, bus.cmd_ready);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_kind  = 4'($urandom_range(0, 15));
    bus.cmd_imm   = 16'($urandom);
    if (!legal) begin
      m_err = 1'b1;
      @(negedge clk);
      n_run++;
      if (bus.imem_we !== 1'b0 || err !== 1'b1 || bus.imem_addr !== exp_a) begin
        n_fail++;
        $display("FAIL %s illegal: got we=%b err=%b addr=%h want we=0 err=1 addr=%h",
                 tag, bus.imem_we, err, bus.imem_addr, exp_a);
      end
      return;
    end
    if (start_in_write) start = 1'b1;
    for (int i = 0; i < ack_after; i++) begin
      @(negedge clk);
      n_run++;
      if (bus.imem_we !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.imem_addr !== exp_a ||
          bus.imem_wdata !== exp_w) begin
        n_fail++;
        $display("FAIL %s write[%0d]: got we=%b rdy=%b addr=%h data=%h want 1 0 %h %h",
                 tag, i, bus.imem_we, bus.cmd_ready, bus.imem_addr, bus.imem_wdata, exp_a, exp_w);
      end
      if (i == ack_after - 1) bus.imem_ack = 1'b1;
      @(posedge clk); #1;
      bus.imem_ack = 1'b0;
    end
    start = 1'b0;
    m_count++;
    @(negedge clk);
    n_run++;
    if (bus.imem_we !== 1'b0 || count !== CW'(m_count) || full !== (m_count == DEPTH) ||
        bus.cmd_ready !== (m_count != DEPTH) || err !== m_err) begin
      n_fail++;
      $display("FAIL %s after_ack: got we=%b cnt=%0d full=%b rdy=%b err=%b want 0 %0d %b %b %b",
               tag, bus.imem_we, count, full, bus.cmd_ready, err, m_count, m_count == DEPTH,
               m_count != DEPTH, m_err);
    end
  endtask

  task automatic pulse_start(input string tag);
    @(posedge clk); #1;
    start         = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_kind  = 4'd0;
    @(negedge clk);
    n_run++;
    if (bus.cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s start_ready: got %b want 0", tag, bus.cmd_ready);
    end
    @(posedge clk); #1;
    start         = 1'b0;
    bus.cmd_valid = 1'b0;
    m_count       = 0;
    m_err         = 1'b0;
    @(negedge clk);
    n_run++;
    if (bus.imem_we !== 1'b0 || count !== '0 || full !== 1'b0 || err !== 1'b0 ||
        bus.imem_addr !== ref_addr()) begin
      n_fail++;
      $display("FAIL %s after_start: got we=%b cnt=%0d full=%b err=%b addr=%h want 0 0 0 0 %h",
               tag, bus.imem_we, count, full, err, bus.imem_addr, ref_addr());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bus.imem_ack = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_kind = 4'd0;
    bus.cmd_rs = '0; bus.cmd_rt = '0; bus.cmd_rd = '0; bus.cmd_imm = '0;
    #12;
    n_run++;
    if (bus.cmd_ready !== 1'b0 || bus.imem_we !== 1'b0 || bus.imem_addr !== ADDR_W'(BASE) ||
        bus.imem_wdata !== 32'h0 || count !== '0 || full !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b we=%b addr=%h data=%h cnt=%0d full=%b err=%b",
               bus.cmd_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, count, full, err);
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; m_count = 0; m_err = 1'b0;
  endtask

  task automatic test_add();
    issue("add", 0, 5'd1, 5'd2, 5'd3, 16'h0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    pulse_start("b2b");
    issue("b2b_lw",    5,  5'd0,  5'd8, 5'd0,  16'h0004, 3, 1'b0);
    issue("b2b_ori",   8,  5'd2,  5'd3, 5'd0,  16'h00FF, 3, 1'b0);
    issue("b2b_baln",  10, 5'd0,  5'd0, 5'd0,  16'hFFFE, 3, 1'b0);
    issue("b2b_jrsal", 9,  5'd31, 5'd0, 5'd17, 16'h0000, 3, 1'b0);
  endtask

  task automatic test_illegal_and_start_in_write();
    issue("illegal13", 13, 5'd4, 5'd5, 5'd6, 16'h1234, 1, 1'b0);
    issue("sw_after",  6,  5'd1, 5'd2, 5'd0, 16'h0008, 2, 1'b0);
    issue("start_in_write", 3, 5'd7, 5'd9, 5'd11, 16'h0, 2, 1'b1);
    pulse_start("clear_err");
  endtask

  task automatic test_reset_mid_write();
    issue("pre_rst", 2, 5'd3, 5'd4, 5'd5, 16'h0, 1, 1'b0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_kind = 4'd7; bus.cmd_imm = 16'h0010;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    n_run++;
    if (bus.imem_we !== 1'b0 || count !== '0 || bus.imem_addr !== ADDR_W'(BASE) ||
        bus.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_write: got we=%b cnt=%0d addr=%h rdy=%b want 0 0 %h 0",
               bus.imem_we, count, bus.imem_addr, bus.cmd_ready, ADDR_W'(BASE));
    end
    @(negedge clk);
    reset = 1'b0; m_count = 0; m_err = 1'b0;
  endtask

  task automatic test_random_fill();
    int guard = 0;
    pulse_start("fill");
    while (m_count < DEPTH && guard < 200) begin
      issue("rand", int'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
            16'($urandom), int'($urandom_range(1, 3)), 1'b0);
      guard++;
    end
    n_run++;
    if (full !== 1'b1 || count !== CW'(DEPTH)) begin
      n_fail++; $display("FAIL fill_full: got full=%b cnt=%0d want 1 %0d", full, count, DEPTH);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_kind = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_run++;
      if (bus.cmd_ready !== 1'b0 || bus.imem_we !== 1'b0 || count !== CW'(DEPTH)) begin
        n_fail++;
        $display("FAIL full_hold[%0d]: got rdy=%b we=%b cnt=%0d want 0 0 %0d",
                 i, bus.cmd_ready, bus.imem_we, count, DEPTH);
      end
    end
    bus.cmd_valid = 1'b0;
    pulse_start("refill");
    issue("after_refill", 4, 5'd10, 5'd20, 5'd30, 16'h0, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_illegal_and_start_in_write();
    test_reset_mid_write();
    test_random_fill();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
